// File: rtl/if_id_queue.sv
// Two-entry fetch-to-decode skid queue: registered outputs, one-cycle push-to-head latency, no write-to-read bypass.
// in_ready depends only on occupancy and flush; flush and rst discard every entry including same-cycle push/pop.
module if_id_queue #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter logic [31:0] PC_RESET  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        pred_taken_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        pred_taken_out,
  input  logic        flush,
  output logic [1:0]  count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e        state_q, state_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] pc_q    [2];
  logic [31:0] instr_q [2];
  logic        pred_q  [2];
  logic        push;
  logic        pop;

  assign in_ready  = (state_q != FULL) && !flush;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case (state_q)
        EMPTY: if (push) state_d = ONE;
        ONE: begin
          // push with pop stays ONE; the new entry becomes head via rd_ptr advance
          if (push && !pop)      state_d = FULL;
          else if (!push && pop) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Payload storage needs no reset: visibility is gated by occupancy alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]    <= pc_in;
      instr_q[wr_ptr_q] <= instr_in;
      pred_q[wr_ptr_q]  <= pred_taken_in;
    end
  end

  always_comb begin
    pc_out         = PC_RESET;
    instr_out      = NOP_INSTR;
    pred_taken_out = 1'b0;
    if (out_valid) begin
      pc_out         = pc_q[rd_ptr_q];
      instr_out      = instr_q[rd_ptr_q];
      pred_taken_out = pred_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Random and directed stimulus against a queue-based model; a negedge monitor compares DUT state and head entry.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        pred_taken_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        pred_taken_out;
  logic        flush = 1'b0;
  logic [1:0]  count;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;

  if_id_queue dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pc_in          (pc_in),
    .instr_in       (instr_in),
    .pred_taken_in  (pred_taken_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .pred_taken_out (pred_taken_out),
    .flush          (flush),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT against the model, consumes the head when decode takes it.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(count), 32'(sb.size()));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 2 && !flush));
      if (sb.size() != 0) begin
        chk("pc_out", pc_out, sb[0].pc);
        chk("instr_out", instr_out, sb[0].instr);
        chk("pred_out", 32'(pred_taken_out), 32'(sb[0].pred));
        if (out_valid && out_ready) void'(sb.pop_front());
      end else begin
        chk("pc_idle", pc_out, 32'h0);
        chk("instr_idle", instr_out, NOP);
        chk("pred_idle", 32'(pred_taken_out), 32'h0);
      end
    end
  end

  always @(posedge clk) begin
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL watchdog: got %0d cycles expected under 20000", cycles);
      $fatal(1, "watchdog expired");
    end
  end

  // Called at posedge+1: drive one cycle, apply the model update at the edge.
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] i,
                      input logic pr, input logic ordy, input logic fl);
    logic acc;
    in_valid      = v;
    pc_in         = p;
    instr_in      = i;
    pred_taken_in = pr;
    out_ready     = ordy;
    flush         = fl;
    acc = v && !fl && (sb.size() < 2);
    @(posedge clk);
    if (fl) sb.delete();
    else if (acc) sb.push_back('{pc: p, instr: i, pred: pr});
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // single pass
    step(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // fill, ignored third offer, drain
    step(1'b1, 32'h100, 32'h00000113, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'h00000193, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'h00000213, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // simultaneous push and pop through pointer wrap
    step(1'b1, 32'h200, 32'h11111111, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++)
      step(1'b1, 32'h200 + 32'(4 * k), 32'h11111111 + 32'(k), k[0], 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // flush priority, then release
    step(1'b1, 32'h300, 32'h22222222, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h304, 32'h22222223, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h308, 32'h22222224, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    step(1'b1, 32'h400, 32'h33333333, 1'b0, 1'b0, 1'b0);
    chk("release_pc", pc_out, 32'h400);
    chk("release_count", 32'(count), 32'h1);
    idle(1'b1);
    idle(1'b0);

    // asynchronous reset while FULL, with a push offered in the same cycle
    step(1'b1, 32'h500, 32'h44444444, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h504, 32'h44444445, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    pc_in    = 32'h508;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pred", 32'(pred_taken_out), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 32'h600, 32'h55555555, 1'b1, 1'b0, 1'b0);
    chk("post_rst_pc", pc_out, 32'h600);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    for (int n = 0; n < 3; n++) idle(1'b1);
    chk("final_count", 32'(count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
